// File: rtl/matmul_stream_ctrl.sv
// Stream front-end and result collector for an NxN systolic matrix-multiply core.
// Define MATMUL_TIMEOUT_EN to abort WAIT after TIMEOUT cycles and raise a sticky err_timeout.
module matmul_stream_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int N            = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic [DATA_WIDTH-1:0]   a_out       [0:N-1][0:N-1],
  output logic                    valid_a_out [0:N-1][0:N-1],
  output logic [DATA_WIDTH-1:0]   b_out       [0:N-1][0:N-1],
  output logic                    valid_b_out [0:N-1][0:N-1],
  input  logic [OUTPUT_WIDTH-1:0] c_in        [0:N-1][0:N-1],
  input  logic                    c_valid_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int NN    = N * N;
  localparam int K_W   = $clog2(2 * NN);
  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {LOAD, LAUNCH, WAIT, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   a_q [0:NN-1];
  logic [DATA_WIDTH-1:0]   a_d [0:NN-1];
  logic [DATA_WIDTH-1:0]   b_q [0:NN-1];
  logic [DATA_WIDTH-1:0]   b_d [0:NN-1];
  logic [OUTPUT_WIDTH-1:0] c_q [0:NN-1];
  logic [OUTPUT_WIDTH-1:0] c_d [0:NN-1];
  logic [OUTPUT_WIDTH-1:0] c_flat [0:NN-1];
  logic [IDX_W-1:0]        a_idx, b_idx;

`ifdef MATMUL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
`endif

  // Matrices are held flat, row-major, so the beat counter indexes them directly.
  assign a_idx = IDX_W'(k_q);
  assign b_idx = IDX_W'(k_q - K_W'(NN));

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign a_out[i][j]       = a_q[i*N+j];
      assign b_out[i][j]       = b_q[i*N+j];
      assign valid_a_out[i][j] = (state_q == LAUNCH);
      assign valid_b_out[i][j] = (state_q == LAUNCH);
      assign c_flat[i*N+j]     = c_in[i][j];
    end
  end

  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q != LOAD);
  assign m_valid = (state_q == DRAIN);
  assign m_data  = (state_q == DRAIN) ? c_q[idx_q] : '0;
  assign m_last  = (state_q == DRAIN) && (idx_q == IDX_W'(NN - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
`ifdef MATMUL_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (s_valid) begin
          if (k_q < K_W'(NN)) a_d[a_idx] = s_data;
          else                b_d[b_idx] = s_data;
          if (k_q == K_W'(2 * NN - 1)) begin
            k_d     = '0;
            state_d = LAUNCH;
`ifdef MATMUL_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef MATMUL_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (c_valid_in) begin
          c_d     = c_flat;
          idx_d   = '0;
          state_d = DRAIN;
        end
`ifdef MATMUL_TIMEOUT_EN
        else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (m_ready) begin
          if (idx_q == IDX_W'(NN - 1)) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      k_q     <= '0;
      idx_q   <= '0;
      for (int e = 0; e < NN; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
        c_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

`ifdef MATMUL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed-sequence bench for matmul_stream_ctrl with a behavioural multiply core and
// an expected-result model computed from the streamed matrices.
module tb_matmul_stream_ctrl;

  localparam int DW = 8;
  localparam int OW = 16;
  localparam int N  = 3;
  localparam int NN = N * N;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [DW-1:0] a_out       [0:N-1][0:N-1];
  logic          valid_a_out [0:N-1][0:N-1];
  logic [DW-1:0] b_out       [0:N-1][0:N-1];
  logic          valid_b_out [0:N-1][0:N-1];
  logic [OW-1:0] c_in        [0:N-1][0:N-1];
  logic          c_valid_in = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [OW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          err_timeout;

  int checks   = 0;
  int failures = 0;
  int a_m   [NN];
  int b_m   [NN];
  int c_exp [NN];

  always #5 clk = ~clk;

  matmul_stream_ctrl #(
    .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .N(N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .a_out(a_out), .valid_a_out(valid_a_out),
    .b_out(b_out), .valid_b_out(valid_b_out),
    .c_in(c_in), .c_valid_in(c_valid_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int validCount();
    int c = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        c += int'(valid_a_out[i][j]) + int'(valid_b_out[i][j]);
    return c;
  endfunction

  function automatic int abSum();
    int s = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        s += int'(a_out[i][j]) + int'(b_out[i][j]);
    return s;
  endfunction

  function automatic int abMismatches();
    int bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (int'(a_out[i][j]) != a_m[i*N+j]) bad++;
        if (int'(b_out[i][j]) != b_m[i*N+j]) bad++;
      end
    return bad;
  endfunction

  // Expected product from the matrices the bench itself streamed, wrapped to OW bits.
  task automatic computeExpected();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int acc = 0;
        for (int k = 0; k < N; k++) acc += a_m[i*N+k] * b_m[k*N+j];
        c_exp[i*N+j] = acc & 32'hFFFF;
      end
  endtask

  task automatic randomMatrices();
    for (int e = 0; e < NN; e++) begin
      a_m[e] = int'($urandom_range(0, 255));
      b_m[e] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_m_last"}, 32'(m_last), 32'd0);
    checkOutput({tag, "_m_data"}, 32'(m_data), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_timeout), 32'd0);
    checkOutput({tag, "_valids"}, 32'(validCount()), 32'd0);
    checkOutput({tag, "_ab"}, 32'(abSum()), 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0; s_valid = 1'b0; c_valid_in = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
  endtask

  // Streams A then B; returns at the negedge of the first WAIT cycle.
  task automatic applyStimulus(input bit gaps, input int spurious_at);
    int n = 0;
    int cyc = 0;
    bit ready_ok = 1'b1;
    bit spur_armed = 1'b0;
    bit spur_done = 1'b0;
    computeExpected();
    while (n < 2 * NN && cyc < 500) begin
      @(negedge clk);
      if (spur_armed) begin
        c_valid_in = 1'b0;
        spur_armed = 1'b0;
        checkOutput("spur_busy", 32'(busy), 32'd0);
        checkOutput("spur_s_ready", 32'(s_ready), 32'd1);
        checkOutput("spur_m_valid", 32'(m_valid), 32'd0);
      end else if (n == spurious_at && !spur_done) begin
        c_valid_in = 1'b1;
        spur_armed = 1'b1;
        spur_done  = 1'b1;
      end
      if (!s_ready) ready_ok = 1'b0;
      if (validCount() != 0) ready_ok = 1'b0;
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = DW'(n < NN ? a_m[n] : b_m[n-NN]);
      if (s_valid && s_ready) n++;
      cyc++;
    end
    checkOutput("load_beats", 32'(n), 32'(2 * NN));
    checkOutput("load_ready_no_valid", 32'(ready_ok), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    c_valid_in = 1'b0;
    checkOutput("launch_valids", 32'(validCount()), 32'(2 * NN));
    checkOutput("launch_busy", 32'(busy), 32'd1);
    checkOutput("launch_s_ready", 32'(s_ready), 32'd0);
    checkOutput("launch_ab", 32'(abMismatches()), 32'd0);
    @(negedge clk);
    checkOutput("wait_valids", 32'(validCount()), 32'd0);
    checkOutput("wait_busy", 32'(busy), 32'd1);
  endtask

  // Behavioural core: multiplies what the DUT presented and pulses c_valid_in once.
  task automatic respondCore(input int delay);
    for (int d = 0; d < delay; d++) begin
      checkOutput("wait_m_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int acc = 0;
        for (int k = 0; k < N; k++) acc += int'(a_out[i][k]) * int'(b_out[k][j]);
        c_in[i][j] = OW'(acc);
      end
    c_valid_in = 1'b1;
    @(negedge clk);
    c_valid_in = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_in[i][j] = OW'($urandom);
  endtask

  task automatic drainResults(input int stall_at, input int stall_len, input int reset_at);
    int i = 0;
    int cyc = 0;
    int stall = 0;
    while (i < NN && cyc < 200) begin
      if (i == reset_at) begin
        rst_n = 1'b0;
        #1;
        checkResetState("mid_drain");
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b0;
        return;
      end
      checkOutput("m_valid", 32'(m_valid), 32'd1);
      checkOutput("m_data", 32'(m_data), 32'(c_exp[i]));
      checkOutput("m_last", 32'(m_last), 32'(i == NN - 1));
      if (i == stall_at && stall < stall_len) begin
        m_ready = 1'b0;
        stall++;
      end else begin
        m_ready = 1'b1;
      end
      @(negedge clk);
      if (m_ready) i++;
      cyc++;
    end
    m_ready = 1'b0;
    checkOutput("drain_count", 32'(i), 32'(NN));
    checkOutput("post_s_ready", 32'(s_ready), 32'd1);
    checkOutput("post_m_valid", 32'(m_valid), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_in[i][j] = '0;

    doReset();

    $display("[TB] identity x 1..9");
    for (int e = 0; e < NN; e++) begin
      a_m[e] = (e % (N + 1) == 0) ? 1 : 0;
      b_m[e] = e + 1;
    end
    applyStimulus(1'b0, -1);
    respondCore(3);
    drainResults(-1, 0, -1);

    $display("[TB] input gaps, all 2 x all 3");
    for (int e = 0; e < NN; e++) begin
      a_m[e] = 2;
      b_m[e] = 3;
    end
    applyStimulus(1'b1, -1);
    respondCore(1);
    drainResults(-1, 0, -1);

    $display("[TB] output backpressure at idx 4");
    randomMatrices();
    applyStimulus(1'b0, -1);
    respondCore(2);
    drainResults(4, 5, -1);

    $display("[TB] spurious c_valid_in during load");
    randomMatrices();
    applyStimulus(1'b0, 5);
    respondCore(0);
    drainResults(-1, 0, -1);

    $display("[TB] reset mid drain");
    randomMatrices();
    applyStimulus(1'b1, -1);
    respondCore(1);
    drainResults(-1, 0, 3);
    randomMatrices();
    applyStimulus(1'b1, -1);
    respondCore(4);
    drainResults(int'($urandom_range(0, NN - 1)), 3, -1);

`ifdef MATMUL_TIMEOUT_EN
    $display("[TB] core timeout");
    randomMatrices();
    applyStimulus(1'b0, -1);
    for (int w = 0; w < TO; w++) begin
      checkOutput("to_err_early", 32'(err_timeout), 32'd0);
      checkOutput("to_m_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
    end
    checkOutput("to_err_set", 32'(err_timeout), 32'd1);
    checkOutput("to_s_ready", 32'(s_ready), 32'd1);
    checkOutput("to_busy", 32'(busy), 32'd0);
    checkOutput("to_m_valid_after", 32'(m_valid), 32'd0);
    randomMatrices();
    applyStimulus(1'b0, -1);
    checkOutput("to_err_cleared", 32'(err_timeout), 32'd0);
    respondCore(1);
    drainResults(-1, 0, -1);
`endif

    $display("[TB] random transactions");
    for (int t = 0; t < 3; t++) begin
      randomMatrices();
      applyStimulus(1'b1, -1);
      respondCore(int'($urandom_range(0, 6)));
      drainResults(int'($urandom_range(0, NN - 1)), int'($urandom_range(0, 4)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
